// File: rtl/supercar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : supercar_pkg
// Description : Shared state encoding, defaults and helpers for the Supercar
//               light-bar sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package supercar_pkg;

    localparam int c_N_BIT_DEFAULT = 4;
    localparam int c_DIV_W_DEFAULT = 24;
    localparam int c_STATE_W       = 3;

    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_LOAD  = 3'd1;
    localparam state_t c_ST_LEFT  = 3'd2;
    localparam state_t c_ST_RIGHT = 3'd3;
    localparam state_t c_ST_CLEAR = 3'd4;

    // True in the two states where the lit bit is actually moving.
    function automatic logic is_sweeping(input state_t s);
        return (s == c_ST_LEFT) || (s == c_ST_RIGHT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/supercar_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : supercar_prescaler
// Description : Shift-rate prescaler. Counts clk cycles and raises tick once
//               every div_q+1 cycles while run is high. The period value is
//               latched only at a tick (or on clr), so a new div_val never
//               truncates or stretches the period in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module supercar_prescaler
    import supercar_pkg::*;
#(
    parameter int DIV_W = c_DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick
);

    localparam logic [DIV_W-1:0] c_CNT_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;
    logic             w_expired;

    // Greater-or-equal keeps the counter safe if div_q ever shrinks below cnt.
    assign w_expired = (r_cnt >= r_div_q);
    assign tick      = run & w_expired;

    // Period counter and latched period; clr restarts a fresh period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_div_q <= '0;
        end else if (clr) begin
            r_cnt   <= '0;
            r_div_q <= div_val;
        end else if (run) begin
            if (w_expired) begin
                r_cnt   <= '0;
                r_div_q <= div_val;
            end else begin
                r_cnt   <= r_cnt + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/supercar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : supercar_ctrl
// Description : Supercar light-bar sequencer. Drives the strobes of an N_BIT
//               bidirectional shift register so a single lit bit bounces
//               between bit 0 and bit N_BIT-1 at a programmable rate. All
//               strobes decode registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module supercar_ctrl
    import supercar_pkg::*;
#(
    parameter int N_BIT = c_N_BIT_DEFAULT,
    parameter int DIV_W = c_DIV_W_DEFAULT,
    parameter int POS_W = $clog2(N_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div_val,
    output logic             sh_en,
    output logic             sh_pl,
    output logic             sh_l_nr,
    output logic             sh_sin,
    output logic [N_BIT-1:0] sh_pin,
    output logic             busy,
    output logic [POS_W-1:0] pos
);

    // Turn-around points: the last tick in LEFT leaves from N_BIT-2, the last
    // tick in RIGHT leaves from 1, so pos reverses exactly at the end bits.
    localparam logic [POS_W-1:0] c_POS_TURN_RIGHT = POS_W'(N_BIT - 2);
    localparam logic [POS_W-1:0] c_POS_TURN_LEFT  = POS_W'(1);
    localparam logic [POS_W-1:0] c_POS_ONE        = POS_W'(1);
    localparam logic [N_BIT-1:0] c_PIN_SEED       = N_BIT'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [POS_W-1:0] r_pos;
    logic             w_tick;
    logic             w_run;
    logic             w_clr;

    assign w_run = is_sweeping(r_state);
    assign w_clr = (r_state == c_ST_LOAD);
    assign pos   = r_pos;

    supercar_prescaler #(
        .DIV_W   (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .run     (w_run),
        .clr     (w_clr),
        .div_val (div_val),
        .tick    (w_tick)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: stop dominates start, start only acts from IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start && !stop) begin
                    w_next_state = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_next_state = stop ? c_ST_CLEAR : c_ST_LEFT;
            end
            c_ST_LEFT: begin
                if (stop) begin
                    w_next_state = c_ST_CLEAR;
                end else if (w_tick && (r_pos == c_POS_TURN_RIGHT)) begin
                    w_next_state = c_ST_RIGHT;
                end
            end
            c_ST_RIGHT: begin
                if (stop) begin
                    w_next_state = c_ST_CLEAR;
                end else if (w_tick && (r_pos == c_POS_TURN_LEFT)) begin
                    w_next_state = c_ST_LEFT;
                end
            end
            c_ST_CLEAR: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Strobe decode from state and the registered prescaler compare.
    always_comb begin
        sh_en   = 1'b0;
        sh_pl   = 1'b0;
        sh_l_nr = 1'b0;
        sh_sin  = 1'b0;
        sh_pin  = '0;
        busy    = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_LOAD: begin
                sh_en  = 1'b1;
                sh_pl  = 1'b1;
                sh_pin = c_PIN_SEED;
            end
            c_ST_LEFT: begin
                sh_en   = w_tick;
                sh_l_nr = 1'b1;
            end
            c_ST_RIGHT: begin
                sh_en   = w_tick;
            end
            c_ST_CLEAR: begin
                sh_en  = 1'b1;
                sh_pl  = 1'b1;
            end
            default: begin
                sh_en  = 1'b0;
            end
        endcase
    end

    // Position tracker mirrors the shift register: moves on each shift tick,
    // and returns to 0 on both the initial load and the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos <= '0;
        end else begin
            case (r_state)
                c_ST_LOAD, c_ST_CLEAR: begin
                    r_pos <= '0;
                end
                c_ST_LEFT: begin
                    if (w_tick) begin
                        r_pos <= r_pos + c_POS_ONE;
                    end
                end
                c_ST_RIGHT: begin
                    if (w_tick) begin
                        r_pos <= r_pos - c_POS_ONE;
                    end
                end
                default: begin
                    r_pos <= r_pos;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_supercar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_supercar_ctrl
// Description : Scoreboard bench for supercar_ctrl with N_BIT=4. A shift
//               register model follows the strobes; every sh_en pulse is
//               matched against a hand-computed expected strobe record.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_supercar_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int PW = 2;

    typedef struct {
        int           cyc;
        logic         pl;
        logic         lnr;
        logic [N-1:0] pin;
        int           pos;
        logic [N-1:0] bar;
    } exp_t;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic [DW-1:0] div_val = '0;
    logic          sh_en;
    logic          sh_pl;
    logic          sh_l_nr;
    logic          sh_sin;
    logic [N-1:0]  sh_pin;
    logic          busy;
    logic [PW-1:0] pos;

    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;
    logic [N-1:0]  bar;
    exp_t          exp_q[$];
    exp_t          m_e;
    logic [N-1:0]  m_nb;
    int            L;
    int            L2;

    supercar_ctrl #(
        .N_BIT   (N),
        .DIV_W   (DW),
        .POS_W   (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .div_val (div_val),
        .sh_en   (sh_en),
        .sh_pl   (sh_pl),
        .sh_l_nr (sh_l_nr),
        .sh_sin  (sh_sin),
        .sh_pin  (sh_pin),
        .busy    (busy),
        .pos     (pos)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] sr_next(input logic [N-1:0] b, input logic pl,
                                             input logic lnr, input logic sin,
                                             input logic [N-1:0] pin);
        if (pl) return pin;
        if (lnr) return {b[N-2:0], sin};
        return {sin, b[N-1:1]};
    endfunction

    // Downstream shift register model driving the LED bar.
    always @(posedge clk or posedge rst) begin
        if (rst) bar <= '0;
        else if (sh_en) bar <= sr_next(bar, sh_pl, sh_l_nr, sh_sin, sh_pin);
    end

    // Monitor: every strobe must match the next expected record.
    always @(negedge clk) begin
        if (sh_en === 1'b1) begin
            checks++;
            m_nb = sr_next(bar, sh_pl, sh_l_nr, sh_sin, sh_pin);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected sh_en at cyc=%0d pl=%b l_nr=%b pin=%b pos=%0d, required no strobe",
                         cyc, sh_pl, sh_l_nr, sh_pin, pos);
            end else begin
                m_e = exp_q.pop_front();
                if (cyc != m_e.cyc || sh_pl !== m_e.pl || sh_l_nr !== m_e.lnr ||
                    sh_sin !== 1'b0 || sh_pin !== m_e.pin || int'(pos) != m_e.pos ||
                    m_nb !== m_e.bar) begin
                    errors++;
                    $display("FAIL strobe: got cyc=%0d pl=%b l_nr=%b sin=%b pin=%b pos=%0d bar=%b, required cyc=%0d pl=%b l_nr=%b sin=0 pin=%b pos=%0d bar=%b",
                             cyc, sh_pl, sh_l_nr, sh_sin, sh_pin, pos, m_nb,
                             m_e.cyc, m_e.pl, m_e.lnr, m_e.pin, m_e.pos, m_e.bar);
                end
            end
        end
    end

    task automatic push(input int c, input logic pl, input logic lnr,
                        input logic [N-1:0] pin, input int p, input logic [N-1:0] b);
        exp_t e;
        e.cyc = c; e.pl = pl; e.lnr = lnr; e.pin = pin; e.pos = p; e.bar = b;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sh_en"},   {31'd0, sh_en},   0);
        check({tag, "_sh_pl"},   {31'd0, sh_pl},   0);
        check({tag, "_sh_l_nr"}, {31'd0, sh_l_nr}, 0);
        check({tag, "_sh_sin"},  {31'd0, sh_sin},  0);
        check({tag, "_sh_pin"},  {28'd0, sh_pin},  0);
        check({tag, "_busy"},    {31'd0, busy},    0);
        check({tag, "_pos"},     {30'd0, pos},     0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        step();
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();
        check("idle_busy", {31'd0, busy}, 0);

        // Full-speed bounce, then stop right after the first return to LEFT.
        div_val = 8'd0;
        start   = 1'b1;
        L       = cyc + 1;
        push(L,     1, 0, 4'b0001, 0, 4'b0001);
        push(L + 1, 0, 1, 4'b0000, 0, 4'b0010);
        push(L + 2, 0, 1, 4'b0000, 1, 4'b0100);
        push(L + 3, 0, 1, 4'b0000, 2, 4'b1000);
        push(L + 4, 0, 0, 4'b0000, 3, 4'b0100);
        push(L + 5, 0, 0, 4'b0000, 2, 4'b0010);
        push(L + 6, 0, 0, 4'b0000, 1, 4'b0001);
        push(L + 7, 0, 1, 4'b0000, 0, 4'b0010);
        push(L + 8, 1, 0, 4'b0000, 1, 4'b0000);
        step();
        start = 1'b0;
        check("load_busy", {31'd0, busy}, 1);
        wait_cyc(L + 7);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        check("t1_busy", {31'd0, busy}, 0);
        check("t1_bar",  {28'd0, bar},  0);
        check("t1_pos",  {30'd0, pos},  0);

        // div_val=3 bounce, switch to 1 mid-period, stop on a LEFT tick at pos 1.
        div_val = 8'd3;
        start   = 1'b1;
        L       = cyc + 1;
        push(L,      1, 0, 4'b0001, 0, 4'b0001);
        push(L + 4,  0, 1, 4'b0000, 0, 4'b0010);
        push(L + 8,  0, 1, 4'b0000, 1, 4'b0100);
        push(L + 12, 0, 1, 4'b0000, 2, 4'b1000);
        push(L + 16, 0, 0, 4'b0000, 3, 4'b0100);
        push(L + 20, 0, 0, 4'b0000, 2, 4'b0010);
        push(L + 24, 0, 0, 4'b0000, 1, 4'b0001);
        push(L + 28, 0, 1, 4'b0000, 0, 4'b0010);
        push(L + 32, 0, 1, 4'b0000, 1, 4'b0100);
        push(L + 34, 0, 1, 4'b0000, 2, 4'b1000);
        push(L + 36, 0, 0, 4'b0000, 3, 4'b0100);
        push(L + 38, 0, 0, 4'b0000, 2, 4'b0010);
        push(L + 40, 0, 0, 4'b0000, 1, 4'b0001);
        push(L + 42, 0, 1, 4'b0000, 0, 4'b0010);
        push(L + 44, 0, 1, 4'b0000, 1, 4'b0100);
        push(L + 45, 1, 0, 4'b0000, 2, 4'b0000);
        step();
        start = 1'b0;
        wait_cyc(L + 29);
        div_val = 8'd1;
        wait_cyc(L + 44);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("clear_busy", {31'd0, busy}, 1);
        step();
        check("t4_busy", {31'd0, busy}, 0);
        check("t4_bar",  {28'd0, bar},  0);

        // start+stop together in IDLE: no strobes, stays idle.
        start = 1'b1;
        stop  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("both_idle_busy", {31'd0, busy}, 0);
        end
        stop = 1'b0;
        L2   = cyc + 1;
        push(L2,      1, 0, 4'b0001, 0, 4'b0001);
        push(L2 + 2,  0, 1, 4'b0000, 0, 4'b0010);
        push(L2 + 3,  1, 0, 4'b0000, 1, 4'b0000);
        push(L2 + 5,  1, 0, 4'b0001, 0, 4'b0001);
        push(L2 + 7,  0, 1, 4'b0000, 0, 4'b0010);
        push(L2 + 9,  0, 1, 4'b0000, 1, 4'b0100);
        push(L2 + 11, 0, 1, 4'b0000, 2, 4'b1000);
        push(L2 + 13, 0, 0, 4'b0000, 3, 4'b0100);
        wait_cyc(L2 + 2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        check("restart_gap_busy", {31'd0, busy}, 0);
        step();
        check("restart_load_busy", {31'd0, busy}, 1);

        // Asynchronous reset while sweeping right.
        wait_cyc(L2 + 14);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        check("rst_mid_bar", {28'd0, bar}, 0);
        step();
        rst = 1'b0;
        push(L2 + 16, 1, 0, 4'b0001, 0, 4'b0001);
        push(L2 + 18, 0, 1, 4'b0000, 0, 4'b0010);
        step();
        check("post_rst_busy", {31'd0, busy}, 1);
        wait_cyc(L2 + 18);
        start = 1'b0;
        stop  = 1'b1;
        push(L2 + 19, 1, 0, 4'b0000, 1, 4'b0000);
        step();
        stop = 1'b0;
        step();
        check("end_busy", {31'd0, busy}, 0);
        check("end_pos",  {30'd0, pos},  0);
        check("end_bar",  {28'd0, bar},  0);
        step();
        step();
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
